wb_arbiter: RTL and testbench

Two-master, one-slave Wishbone arbiter that shares the system bus between the CPU master port (m0) and a second master such as a debug or DMA engine (m1). It grants the bus per Wishbone cycle (`cyc` tenure) with round-robin priority and routes slave responses only to the owner. A watchdog aborts a stalled transfer by returning `err` to the owning master.

---
 rtl/wb_arbiter.sv | 173 +++++++++++++++++
 tb/tb_wb_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter with per-tenure round-robin grant and a
// stall watchdog that aborts a hung transfer with err to the owning master.
module wb_arbiter #(
    parameter int unsigned ADR_WIDTH = 64,
    parameter int unsigned DAT_WIDTH = 64,
    parameter int unsigned SEL_WIDTH = 8,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic [ADR_WIDTH-1:0] m0_adr_i,
    input  logic [DAT_WIDTH-1:0] m0_dat_i,
    input  logic                 m0_we_i,
    input  logic [SEL_WIDTH-1:0] m0_sel_i,
    input  logic                 m0_stb_i,
    input  logic                 m0_cyc_i,
    output logic [DAT_WIDTH-1:0] m0_dat_o,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,

    input  logic [ADR_WIDTH-1:0] m1_adr_i,
    input  logic [DAT_WIDTH-1:0] m1_dat_i,
    input  logic                 m1_we_i,
    input  logic [SEL_WIDTH-1:0] m1_sel_i,
    input  logic                 m1_stb_i,
    input  logic                 m1_cyc_i,
    output logic [DAT_WIDTH-1:0] m1_dat_o,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,

    output logic [ADR_WIDTH-1:0] s_adr_o,
    output logic [DAT_WIDTH-1:0] s_dat_o,
    output logic                 s_we_o,
    output logic [SEL_WIDTH-1:0] s_sel_o,
    output logic                 s_stb_o,
    output logic                 s_cyc_o,
    input  logic [DAT_WIDTH-1:0] s_dat_i,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,

    output logic [1:0]           gnt_o,
    output logic                 timeout_o
);

    localparam int unsigned WdogW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WdogW-1:0] WdogMax = WdogW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StAbort, StDrain} state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [WdogW-1:0] wdog_q, wdog_d;

    logic owner_cyc;
    logic owner_stb;
    logic stall;

    assign owner_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
    assign owner_stb = owner_q ? m1_stb_i : m0_stb_i;
    // Only a live strobe without any response counts toward the watchdog.
    assign stall     = owner_stb & ~s_ack_i & ~s_err_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        unique case (state_q)
            StIdle: begin
                wdog_d = '0;
                if (m0_cyc_i || m1_cyc_i) begin
                    state_d = StBusy;
                    owner_d = (m0_cyc_i && m1_cyc_i) ? ~last_q : m1_cyc_i;
                end
            end
            StBusy: begin
                // Release takes priority over a coincident watchdog expiry.
                if (!owner_cyc) begin
                    last_d  = owner_q;
                    state_d = StIdle;
                    wdog_d  = '0;
                end else if (stall) begin
                    if (TIMEOUT != 0 && wdog_q == WdogMax) begin
                        state_d = StAbort;
                        wdog_d  = '0;
                    end else if (TIMEOUT != 0) begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end else begin
                    wdog_d = '0;
                end
            end
            StAbort: begin
                state_d = StDrain;
            end
            StDrain: begin
                if (!owner_cyc) begin
                    last_d  = owner_q;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        s_stb_o   = 1'b0;
        s_cyc_o   = 1'b0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        gnt_o     = 2'b00;
        timeout_o = 1'b0;
        m0_dat_o  = s_dat_i;
        m1_dat_o  = s_dat_i;
        unique case (state_q)
            StBusy: begin
                gnt_o   = owner_q ? 2'b10 : 2'b01;
                s_adr_o = owner_q ? m1_adr_i : m0_adr_i;
                s_dat_o = owner_q ? m1_dat_i : m0_dat_i;
                s_we_o  = owner_q ? m1_we_i  : m0_we_i;
                s_sel_o = owner_q ? m1_sel_i : m0_sel_i;
                s_stb_o = owner_stb;
                s_cyc_o = owner_cyc;
                if (owner_q) begin
                    m1_ack_o = s_ack_i;
                    m1_err_o = s_err_i;
                end else begin
                    m0_ack_o = s_ack_i;
                    m0_err_o = s_err_i;
                end
            end
            StAbort: begin
                gnt_o     = owner_q ? 2'b10 : 2'b01;
                timeout_o = 1'b1;
                if (owner_q) begin
                    m1_err_o = 1'b1;
                end else begin
                    m0_err_o = 1'b1;
                end
            end
            StDrain: begin
                gnt_o = owner_q ? 2'b10 : 2'b01;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (TIMEOUT=4): grant, tie, lock, watchdog, races, reset.
module tb_wb_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [AW-1:0] m0_adr, m1_adr, s_adr;
    logic [DW-1:0] m0_wdat, m1_wdat, m0_rdat, m1_rdat, s_wdat, s_rdat;
    logic [SW-1:0] m0_sel, m1_sel, s_sel;
    logic          m0_we, m0_stb, m0_cyc, m0_ack, m0_err;
    logic          m1_we, m1_stb, m1_cyc, m1_ack, m1_err;
    logic          s_we, s_stb, s_cyc, s_ack, s_err;
    logic [1:0]    gnt;
    logic          tmo;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .ADR_WIDTH(AW), .DAT_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT(4)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack),
        .m0_err_o(m0_err),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack),
        .m1_err_o(m1_err),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_dat_i(s_rdat), .s_ack_i(s_ack),
        .s_err_i(s_err),
        .gnt_o(gnt), .timeout_o(tmo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic m0_req(input logic cyc, input logic stb, input logic we,
                          input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_wdat = dat; m0_sel = '1;
    endtask

    task automatic m1_req(input logic cyc, input logic stb, input logic we,
                          input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_wdat = dat; m1_sel = '1;
    endtask

    logic [DW-1:0] beat_dat [3];

    initial begin
        beat_dat[0] = 64'h1111_0000_0000_0001;
        beat_dat[1] = 64'h2222_0000_0000_0002;
        beat_dat[2] = 64'h3333_0000_0000_0003;
        rst_i = 1'b0;
        m0_req(0, 0, 0, '0, '0);
        m1_req(0, 0, 0, '0, '0);
        s_ack = 1'b0; s_err = 1'b0; s_rdat = '0;
        settle();
        check("rst_gnt", 64'(gnt), 0);
        check("rst_scyc", 64'(s_cyc), 0);
        check("rst_tmo", 64'(tmo), 0);
        tick(); tick();
        rst_i = 1'b1;

        // Single master read with ack two cycles after stb
        tick();
        m0_req(1, 1, 0, 64'h0000_8000_0000_0000, '0);
        settle();
        check("t1_gnt_pre", 64'(gnt), 0);
        tick();
        check("t1_gnt", 64'(gnt), 64'h1);
        check("t1_scyc", 64'(s_cyc), 1);
        check("t1_sadr", s_adr, 64'h0000_8000_0000_0000);
        tick();
        check("t1_noack", 64'(m0_ack), 0);
        tick();
        s_ack = 1'b1; s_rdat = 64'h0123_4567_89ab_cdef;
        settle();
        check("t1_ack", 64'(m0_ack), 1);
        check("t1_dat", m0_rdat, 64'h0123_4567_89ab_cdef);
        check("t1_m1ack", 64'(m1_ack), 0);
        tick();
        s_ack = 1'b0;
        m0_req(0, 0, 0, '0, '0);
        tick();
        check("t1_release", 64'(gnt), 0);

        // Tie after reset: m0 first, bubble, then m1
        rst_i = 1'b0; settle(); rst_i = 1'b1;
        tick();
        m0_req(1, 1, 0, 64'h100, '0);
        m1_req(1, 1, 0, 64'h200, '0);
        tick();
        check("t2_tie_gnt", 64'(gnt), 64'h1);
        s_ack = 1'b1;
        settle();
        check("t2_m0ack", 64'(m0_ack), 1);
        check("t2_m1ack", 64'(m1_ack), 0);
        tick();
        s_ack = 1'b0;
        m0_req(0, 0, 0, '0, '0);
        settle();
        check("t2_hold", 64'(gnt), 64'h1);
        tick();
        check("t2_bubble", 64'(gnt), 0);
        tick();
        check("t2_m1gnt", 64'(gnt), 64'h2);
        check("t2_sadr", s_adr, 64'h200);
        s_ack = 1'b1;
        settle();
        check("t2_m1ack2", 64'(m1_ack), 1);
        check("t2_m0ack2", 64'(m0_ack), 0);
        tick();
        s_ack = 1'b0;
        m1_req(0, 0, 0, '0, '0);
        tick();
        m0_req(1, 1, 0, 64'h100, '0);
        tick();
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        m0_req(0, 0, 0, '0, '0);
        tick();
        m0_req(1, 1, 0, 64'h100, '0);
        m1_req(1, 1, 0, 64'h200, '0);
        tick();
        check("t2_tie_last0", 64'(gnt), 64'h2);
        m0_req(0, 0, 0, '0, '0);
        m1_req(0, 0, 0, '0, '0);
        tick();
        tick();

        // Locked tenure: m1 writes three beats while m0 waits
        m1_req(1, 1, 1, 64'h300, beat_dat[0]);
        tick();
        check("t3_gnt", 64'(gnt), 64'h2);
        m0_req(1, 1, 0, 64'h400, '0);
        for (int i = 0; i < 3; i++) begin
            m1_wdat = beat_dat[i];
            s_ack   = 1'b1;
            settle();
            check("t3_we", 64'(s_we), 1);
            check("t3_wdat", s_wdat, beat_dat[i]);
            check("t3_m1ack", 64'(m1_ack), 1);
            check("t3_m0ack", 64'(m0_ack), 0);
            check("t3_m0err", 64'(m0_err), 0);
            check("t3_lockgnt", 64'(gnt), 64'h2);
            tick();
        end
        s_ack = 1'b0;
        m1_req(0, 0, 0, '0, '0);
        settle();
        check("t3_dropgnt", 64'(gnt), 64'h2);
        tick();
        check("t3_bubble", 64'(gnt), 0);
        tick();
        check("t3_m0gnt", 64'(gnt), 64'h1);
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        m0_req(0, 0, 0, '0, '0);
        tick();
        tick();

        // Watchdog: m0 read never acked
        m0_req(1, 1, 0, 64'h500, '0);
        tick();
        check("t4_gnt", 64'(gnt), 64'h1);
        check("t4_err0", 64'(m0_err), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t4_noerr", 64'(m0_err), 0);
            check("t4_notmo", 64'(tmo), 0);
            check("t4_scyc", 64'(s_cyc), 1);
        end
        tick();
        check("t4_err", 64'(m0_err), 1);
        check("t4_tmo", 64'(tmo), 1);
        check("t4_ack", 64'(m0_ack), 0);
        check("t4_scyc_abort", 64'(s_cyc), 0);
        check("t4_sstb_abort", 64'(s_stb), 0);
        check("t4_gnt_abort", 64'(gnt), 64'h1);
        tick();
        check("t4_err_drain", 64'(m0_err), 0);
        check("t4_tmo_drain", 64'(tmo), 0);
        check("t4_scyc_drain", 64'(s_cyc), 0);
        check("t4_gnt_drain", 64'(gnt), 64'h1);
        s_ack = 1'b1;
        settle();
        check("t4_ack_drain", 64'(m0_ack), 0);
        s_ack = 1'b0;
        tick();
        check("t4_gnt_drain2", 64'(gnt), 64'h1);
        m0_req(0, 0, 0, '0, '0);
        tick();
        check("t4_idle", 64'(gnt), 0);

        // Race: ack on the expiry cycle
        tick();
        m0_req(1, 1, 0, 64'h600, '0);
        tick(); tick(); tick(); tick();
        s_ack = 1'b1;
        settle();
        check("t5a_ack", 64'(m0_ack), 1);
        check("t5a_err", 64'(m0_err), 0);
        check("t5a_tmo", 64'(tmo), 0);
        tick();
        s_ack = 1'b0;
        settle();
        check("t5a_tmo2", 64'(tmo), 0);
        check("t5a_err2", 64'(m0_err), 0);
        check("t5a_scyc", 64'(s_cyc), 1);
        tick();
        check("t5a_scyc2", 64'(s_cyc), 1);
        m0_req(0, 0, 0, '0, '0);
        tick();
        tick();

        // Race: owner drops cyc on the expiry cycle
        m0_req(1, 1, 0, 64'h700, '0);
        tick(); tick(); tick(); tick();
        m0_cyc = 1'b0;
        settle();
        check("t5b_err", 64'(m0_err), 0);
        check("t5b_tmo", 64'(tmo), 0);
        tick();
        check("t5b_idle", 64'(gnt), 0);
        check("t5b_tmo2", 64'(tmo), 0);
        check("t5b_err2", 64'(m0_err), 0);
        m0_req(0, 0, 0, '0, '0);
        tick();

        // Asynchronous reset while m1 owns the bus
        m1_req(1, 1, 1, 64'h800, 64'hdead_beef);
        tick();
        check("t6_gnt", 64'(gnt), 64'h2);
        #3;
        rst_i = 1'b0;
        s_ack = 1'b1;
        settle();
        check("t6_gnt_rst", 64'(gnt), 0);
        check("t6_scyc", 64'(s_cyc), 0);
        check("t6_sstb", 64'(s_stb), 0);
        check("t6_sadr", s_adr, 0);
        check("t6_swe", 64'(s_we), 0);
        check("t6_sdat", s_wdat, 0);
        check("t6_m1ack", 64'(m1_ack), 0);
        check("t6_tmo", 64'(tmo), 0);
        s_ack = 1'b0;
        m0_req(1, 1, 0, 64'h900, '0);
        tick();
        rst_i = 1'b1;
        tick();
        check("t6_tie_gnt", 64'(gnt), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
